// File: rtl/fb_scanout_arbiter_if.sv
// Host write port and framebuffer RAM port of the scanout arbiter.
// The slave modport is the arbiter side; the master modport is the host/RAM side.
interface fb_scanout_arbiter_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output wr_valid, wr_addr, wr_data, ram_rdata,
        input  wr_ready, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, ram_rdata,
        output wr_ready, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/fb_scanout_arbiter.sv
// Shares a single-port framebuffer RAM between pixel-replicated scanout (priority)
// and a host write port, producing a 3-cycle aligned pixel stream with delayed syncs.
module fb_scanout_arbiter #(
    parameter int unsigned FB_W       = 160,
    parameter int unsigned FB_H       = 120,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned DATA_W     = 8
) (
    input  logic                 clk_pix,
    input  logic                 rst_pix,
    input  logic [9:0]           screen_x,
    input  logic [9:0]           screen_y,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic                 data_enable,
    input  logic                 vblank_only,
    fb_scanout_arbiter_if.slave  bus,
    output logic [DATA_W-1:0]    pix_data,
    output logic                 pix_hsync,
    output logic                 pix_vsync,
    output logic                 pix_de,
    output logic [15:0]          stall_count
);
    localparam int unsigned SCALE   = 1 << SCALE_LOG2;
    localparam int unsigned DLY     = 3;
    localparam int unsigned STALL_W = 16;
    localparam logic [ADDR_W:0]   FB_WORDS = (ADDR_W + 1)'(FB_W * FB_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);
    localparam logic [9:0]        V_ACT    = 10'(V_ACTIVE);

    logic               slot_c, vblank_c, grant_c, in_range_c, line_end_c, row_adv_c;
    logic [ADDR_W-1:0]  slot_addr_c;
    logic [10:0]        y_next_c;

    logic               ram_en_q, ram_en_d;
    logic               ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
    logic               fetch_q, fetch_d;
    logic               rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]  latch_q, latch_d;
    logic [DATA_W-1:0]  pix_q, pix_d;
    logic [DLY-1:0]     hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    // Slot detection, grant decision and row advance conditions
    always_comb begin
        vblank_c    = screen_y >= V_ACT;
        slot_c      = data_enable && (screen_x[SCALE_LOG2-1:0] == '0);
        slot_addr_c = row_base_q + ADDR_W'(screen_x >> SCALE_LOG2);
        grant_c     = !rst_pix && bus.wr_valid && !slot_c && (!vblank_only || vblank_c);
        in_range_c  = {1'b0, bus.wr_addr} < FB_WORDS;
        y_next_c    = 11'(screen_y) + 11'd1;
        row_adv_c   = ((y_next_c & 11'(SCALE - 1)) == 11'd0) && (y_next_c < 11'(V_ACTIVE));
        line_end_c  = de_q[0] && !data_enable;
    end

    // Next-state for the RAM port, read pipeline, sync delays, row base and stall counter
    always_comb begin
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        row_base_d  = row_base_q;
        stall_d     = stall_q;

        if (slot_c) begin
            ram_en_d   = 1'b1;
            ram_addr_d = slot_addr_c;
        end else if (grant_c && in_range_c) begin
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = bus.wr_addr;
            ram_wdata_d = bus.wr_data;
        end

        // Read data arrives two cycles after the slot; the latch holds it until the next fetch
        fetch_d    = slot_c;
        rd_valid_d = fetch_q;
        latch_d    = rd_valid_q ? bus.ram_rdata : latch_q;
        pix_d      = de_q[1] ? latch_d : '0;

        hs_d = {hs_q[DLY-2:0], hsync};
        vs_d = {vs_q[DLY-2:0], vsync};
        de_d = {de_q[DLY-2:0], data_enable};

        if (vblank_c) begin
            row_base_d = '0;
        end else if (line_end_c && row_adv_c) begin
            row_base_d = row_base_q + ROW_STEP;
        end

        if (screen_x == '0 && screen_y == '0) begin
            stall_d = '0;
        end else if (bus.wr_valid && !grant_c && stall_q != '1) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            fetch_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            latch_q     <= '0;
            pix_q       <= '0;
            hs_q        <= '0;
            vs_q        <= '0;
            de_q        <= '0;
            row_base_q  <= '0;
            stall_q     <= '0;
        end else begin
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            fetch_q     <= fetch_d;
            rd_valid_q  <= rd_valid_d;
            latch_q     <= latch_d;
            pix_q       <= pix_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            row_base_q  <= row_base_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.wr_ready  = grant_c;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign pix_data      = pix_q;
    assign pix_hsync     = hs_q[DLY-1];
    assign pix_vsync     = vs_q[DLY-1];
    assign pix_de        = de_q[DLY-1];
    assign stall_count   = stall_q;
endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Directed bench for fb_scanout_arbiter: cycle-level reference model plus literal checks,
// driven by a compressed line timing (64 active pixels, 80 cycles per line).
module tb_fb_scanout_arbiter;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 8;
    localparam int FB_W     = 160;
    localparam int FB_WORDS = 19200;
    localparam int ACT      = 64;
    localparam int LINE     = 80;

    logic        clk_pix = 1'b0;
    logic        rst_pix = 1'b1;
    logic [9:0]  screen_x = '0;
    logic [9:0]  screen_y = 10'd524;
    logic        hsync = 1'b0, vsync = 1'b0, data_enable = 1'b0, vblank_only = 1'b0;
    logic [7:0]  pix_data;
    logic        pix_hsync, pix_vsync, pix_de;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    fb_scanout_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_scanout_arbiter #(
        .FB_W(160), .FB_H(120), .SCALE_LOG2(2), .V_ACTIVE(480), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk_pix     (clk_pix),
        .rst_pix     (rst_pix),
        .screen_x    (screen_x),
        .screen_y    (screen_y),
        .hsync       (hsync),
        .vsync       (vsync),
        .data_enable (data_enable),
        .vblank_only (vblank_only),
        .bus         (bus.slave),
        .pix_data    (pix_data),
        .pix_hsync   (pix_hsync),
        .pix_vsync   (pix_vsync),
        .pix_de      (pix_de),
        .stall_count (stall_count)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Framebuffer RAM: unwritten word a reads back a[7:0]
    logic [7:0] ram [int];
    logic [7:0] rdata_q = '0;
    assign bus.ram_rdata = rdata_q;

    function automatic logic [7:0] ram_rd(input int a);
        return ram.exists(a) ? ram[a] : 8'(a);
    endfunction

    always @(posedge clk_pix) begin
        if (bus.ram_en && bus.ram_we) ram[int'(bus.ram_addr)] = bus.ram_wdata;
        else if (bus.ram_en) rdata_q <= ram_rd(int'(bus.ram_addr));
    end

    // Reference model state
    int          e_stall = 0;
    logic        e_en = 1'b0, e_we = 1'b0;
    logic [14:0] e_addr = '0;
    logic [7:0]  e_wdata = '0, cur_word = '0;
    logic [2:0]  h_de = '0, h_hs = '0, h_vs = '0;
    logic [7:0]  h_word [3];
    logic [7:0]  exp_wr [int];

    function automatic logic [7:0] exp_rd(input int a);
        return exp_wr.exists(a) ? exp_wr[a] : 8'(a);
    endfunction

    always @(negedge clk_pix) begin : compare
        logic slot, vb, grant, inr;
        int   sa;
        if (rst_pix) begin
            chk("reset_ram_port", {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}, 0);
            chk("reset_pix_stall", {pix_data, pix_hsync, pix_vsync, pix_de, bus.wr_ready, stall_count}, 0);
            e_stall = 0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; cur_word = '0;
            h_de = '0; h_hs = '0; h_vs = '0;
            for (int i = 0; i < 3; i++) h_word[i] = '0;
        end else begin
            slot  = data_enable && (int'(screen_x) % 4 == 0);
            vb    = int'(screen_y) >= 480;
            grant = bus.wr_valid && !slot && (!vblank_only || vb);
            inr   = int'(bus.wr_addr) < FB_WORDS;

            chk("wr_ready", bus.wr_ready, grant);
            chk("ram_en", bus.ram_en, e_en);
            chk("ram_we", bus.ram_we, e_we);
            chk("ram_addr", bus.ram_addr, e_addr);
            chk("ram_wdata", bus.ram_wdata, e_wdata);
            chk("pix_de", pix_de, h_de[2]);
            chk("pix_hsync", pix_hsync, h_hs[2]);
            chk("pix_vsync", pix_vsync, h_vs[2]);
            chk("pix_data", pix_data, h_de[2] ? h_word[2] : 8'h00);
            chk("stall_count", stall_count, e_stall);

            // Each 4x4 block shows word (y/4)*FB_W + x/4
            e_en = slot || (grant && inr);
            e_we = grant && inr;
            if (slot) begin
                sa       = (int'(screen_y) / 4) * FB_W + int'(screen_x) / 4;
                e_addr   = 15'(sa);
                cur_word = exp_rd(sa);
            end else if (grant && inr) begin
                e_addr  = bus.wr_addr;
                e_wdata = bus.wr_data;
                exp_wr[int'(bus.wr_addr)] = bus.wr_data;
            end
            h_de = {h_de[1:0], data_enable};
            h_hs = {h_hs[1:0], hsync};
            h_vs = {h_vs[1:0], vsync};
            h_word[2] = h_word[1];
            h_word[1] = h_word[0];
            h_word[0] = cur_word;

            if (screen_x == 0 && screen_y == 0) e_stall = 0;
            else if (bus.wr_valid && !grant && e_stall < 65535) e_stall++;
        end
    end

    // Stimulus helpers
    logic last_ready = 1'b0;
    logic host_pending = 1'b0;
    logic de_on = 1'b1;

    task automatic set_px(input int x, input int y);
        screen_x    = 10'(x);
        screen_y    = 10'(y);
        data_enable = de_on && (x < ACT) && (y < 480);
        hsync       = (x >= 68) && (x < 72);
        vsync       = (y >= 490) && (y < 492);
    endtask

    task automatic hooks(input int x, input int y);
        if (y == 1 && x == 3) begin
            host_pending = 1'b1; bus.wr_addr = 15'd19000; bus.wr_data = 8'hC3;
        end
        if (y == 1 && x == 4) chk("coll_ready_on_slot", last_ready, 0);
        if (y == 1 && x == 5) begin
            chk("coll_ready_after_slot", last_ready, 1);
            chk("coll_write_port", {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}, {2'b11, 15'd19000, 8'hC3});
            chk("coll_stall", stall_count, 1);
        end
        if (y == 4 && x == 0) chk("row4_base_addr", bus.ram_addr, 160);
        if (y == 5 && x == 8) chk("row5_addr162", {bus.ram_en, bus.ram_we, bus.ram_addr}, {2'b10, 15'd162});
        if (y == 5 && x >= 10 && x <= 13) chk("row5_pix_a2", pix_data, 8'hA2);
    endtask

    task automatic pix_cycle(input int x, input int y);
        set_px(x, y);
        bus.wr_valid = host_pending;
        #1;
        last_ready = bus.wr_ready;
        @(posedge clk_pix);
        #1;
        if (last_ready) host_pending = 1'b0;
        hooks(x, y);
    endtask

    task automatic do_line(input int y);
        for (int x = 0; x < LINE; x++) pix_cycle(x, y);
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        repeat (3) @(posedge clk_pix);
        #1;
        rst_pix = 1'b0;

        // Frame from vblank: scanout of lines 0..5, collision on line 1
        do_line(524);
        for (int y = 0; y < 6; y++) do_line(y);
        chk("coll_mem_written", ram_rd(19000), 8'hC3);

        // Host restricted to vertical blanking
        de_on = 1'b0; vblank_only = 1'b1;
        pix_cycle(0, 0);
        host_pending = 1'b1; bus.wr_addr = 15'd500; bus.wr_data = 8'h11;
        for (int y = 100; y < 104; y++) do_line(y);
        chk("vbo_still_denied", last_ready, 0);
        chk("vbo_stall_320", stall_count, 320);
        de_on = 1'b1;
        pix_cycle(0, 480);
        chk("vbo_grant_at_480", last_ready, 1);
        chk("vbo_stall_kept", stall_count, 320);
        for (int x = 1; x < LINE; x++) pix_cycle(x, 480);
        chk("vbo_mem_written", ram_rd(500), 8'h11);
        do_line(490);

        // Out-of-range write: acknowledged but dropped
        vblank_only = 1'b0;
        host_pending = 1'b1; bus.wr_addr = 15'd19200; bus.wr_data = 8'h5A;
        pix_cycle(0, 481);
        chk("oor_ready", last_ready, 1);
        chk("oor_no_ram_en", bus.ram_en, 0);
        pix_cycle(1, 481);
        chk("oor_mem_unchanged", ram_rd(19200), 8'h00);

        // Stall counter saturation and frame-start clear
        de_on = 1'b0; vblank_only = 1'b1;
        host_pending = 1'b1; bus.wr_addr = 15'd10; bus.wr_data = 8'h99;
        for (int i = 0; i < 65540; i++) pix_cycle(1, 200);
        chk("stall_saturated", stall_count, 16'hFFFF);
        pix_cycle(0, 0);
        chk("stall_cleared", stall_count, 0);
        host_pending = 1'b0; vblank_only = 1'b0;
        pix_cycle(1, 0);
        de_on = 1'b1;

        // Reset asserted mid-line with a granted write in flight
        do_line(524);
        do_line(0);
        do_line(1);
        for (int x = 0; x < 21; x++) pix_cycle(x, 2);
        host_pending = 1'b1; bus.wr_addr = 15'd100; bus.wr_data = 8'h77;
        set_px(21, 2);
        bus.wr_valid = 1'b1;
        #1;
        chk("rst_pre_grant", bus.wr_ready, 1);
        rst_pix = 1'b1;
        #1;
        chk("rst_async_ram", {bus.ram_en, bus.ram_we}, 0);
        chk("rst_async_pix", {pix_de, pix_data}, 0);
        chk("rst_async_ready", bus.wr_ready, 0);
        host_pending = 1'b0;
        bus.wr_valid = 1'b0;
        @(posedge clk_pix);
        #1;
        pix_cycle(22, 2);
        pix_cycle(23, 2);
        rst_pix = 1'b0;
        for (int x = 24; x < LINE; x++) pix_cycle(x, 2);
        for (int y = 3; y < 6; y++) do_line(y);
        chk("rst_write_lost", ram_rd(100), 8'h64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fb_scanout_arbiter.md
Name: fb_scanout_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between display scanout and a host write port.
- Runs in the pixel clock domain, downstream of simple_480p. It consumes screen_x, screen_y, hsync, vsync and data_enable.
- Scanout fetches one word per SCALE×SCALE pixel block and has absolute priority; host writes take the remaining cycles.
- Outputs are a pipeline-aligned pixel stream plus delayed sync signals, feeding the HDMI encoder.

Parameters:
FB_W, 160, framebuffer width in words (= H_ACTIVE/SCALE)
FB_H, 120, framebuffer height in words (= V_ACTIVE/SCALE)
SCALE_LOG2, 2, log2 of pixel replication factor (SCALE=4)
V_ACTIVE, 480, active lines; screen_y >= V_ACTIVE is vertical blanking
ADDR_W, 15, RAM address width (must cover FB_W*FB_H)
DATA_W, 8, word/pixel width

Ports:
clk_pix  in  1  pixel clock
rst_pix  in  1  asynchronous active-high reset
screen_x  in  10  current pixel column from timing generator
screen_y  in  10  current line from timing generator
hsync  in  1  horizontal sync from timing generator
vsync  in  1  vertical sync from timing generator
data_enable  in  1  active-video flag from timing generator
vblank_only  in  1  1 = host writes granted only during vertical blanking
wr_valid  in  1  host write request
wr_ready  out  1  host write accepted this cycle
wr_addr  in  ADDR_W  host write word address
wr_data  in  DATA_W  host write data
ram_en  out  1  RAM enable (registered)
ram_we  out  1  RAM write enable (registered)
ram_addr  out  ADDR_W  RAM address (registered)
ram_wdata  out  DATA_W  RAM write data (registered)
ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0
pix_data  out  DATA_W  scanout pixel
pix_hsync  out  1  hsync delayed 3 cycles
pix_vsync  out  1  vsync delayed 3 cycles
pix_de  out  1  data_enable delayed 3 cycles
stall_count  out  16  host-denied cycles this frame, saturating

Behaviour:
- Reset clears all registered outputs, pipelines, row_base and stall_count to 0 immediately. A write in flight at reset assertion is lost and is never re-issued.
- Display slot (cycle T): slot = data_enable && screen_x[SCALE_LOG2-1:0]==0.
- Slot address = row_base + (screen_x >> SCALE_LOG2).
- row_base register:
  - Forced to 0 while screen_y >= V_ACTIVE.
  - On the data_enable 1→0 edge (end of active line y), if ((y+1) & (SCALE-1))==0 and y+1 < V_ACTIVE, row_base += FB_W; otherwise it is unchanged.
  - Uses an adder only; no multiplier.
- RAM timing for a slot at T:
  - T+1: ram_en=1, ram_we=0, ram_addr = slot address.
  - T+2: ram_rdata valid; loaded into the pixel latch at the end of T+2.
  - T+3: pix_data shows the latch value.
- Pixel hold: the latch holds until the next slot's load, so each word is shown for SCALE consecutive pixels. pix_data = 0 whenever pix_de = 0.
- Sync delay: pix_hsync, pix_vsync and pix_de are the inputs delayed exactly 3 cycles, so they are aligned with pix_data.
- Host grant at T:
  - grant = wr_valid && !slot && (!vblank_only || screen_y >= V_ACTIVE).
  - wr_ready = grant, combinational in the same cycle. Host data and address are sampled on that cycle.
  - A granted write drives ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data at T+1.
  - If wr_addr >= FB_W*FB_H, the write is still acknowledged (wr_ready=1) but dropped: ram_en=0 at T+1.
- Idle cycle (no slot, no grant): ram_en=0, ram_we=0; ram_addr and ram_wdata hold their previous values.
- Slot/write collision: the slot always wins. The host must hold wr_valid/wr_addr/wr_data stable until wr_ready.
- stall_count:
  - Increments by 1 each cycle with wr_valid && !grant; saturates at 0xFFFF.
  - Cleared to 0 in the cycle screen_x==0 && screen_y==0. Clear takes priority over increment.

Test Plan:
- Reset: assert rst_pix mid-line with wr_valid=1 → all outputs 0 asynchronously, no RAM write issued; after release, scanout resumes aligned on the next slot.
- Scanout: preload mem[a]=a[7:0]; line y=5, x=8 → ram_addr=162 one cycle after x=8; pix_data=0xA2 for 4 pixels starting 3 cycles after x=8. Line y=4 fetches from row_base=160.
- Collision: wr_valid held from x=4 (slot, active video) → wr_ready=0 at x=4, 1 at x=5, RAM write at x=6 with ram_we=1; stall_count=1.
- vblank_only=1: wr_valid asserted at y=100 → wr_ready stays 0 until y=480, x=0, then the grant occurs; stall_count reflects every denied cycle.
- Out-of-range: wr_addr=19200 → wr_ready=1, ram_en stays 0 the next cycle, memory unchanged.
- Saturation/clear: deny a write for more than 65535 cycles → stall_count=0xFFFF; it returns to 0 at the next x=0, y=0.
